// File: rtl/data_bus.sv
// CPU data bus: word RAM, GPIO, cycle counter and a UART transmitter fed by a 4-deep FIFO.
// All reads are registered and return pre-edge state; RAM is never cleared by reset.
module data_bus #(
    parameter int RAM_WORDS    = 1024,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] raddr,
    input  logic        re,
    output logic [15:0] rdata,
    input  logic [15:0] waddr,
    input  logic [15:0] wdata,
    input  logic        we,
    output logic [15:0] gpio_out,
    output logic        uart_tx
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [15:0]   RAM_LIMIT = 16'(RAM_WORDS);
    localparam logic [15:0]   A_GPIO    = 16'hFF00;
    localparam logic [15:0]   A_CYCLES  = 16'hFF01;
    localparam logic [15:0]   A_TXDATA  = 16'hFF02;
    localparam logic [15:0]   A_STATUS  = 16'hFF03;
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);

    // state   | meaning
    // S_IDLE  | line high, waiting for a FIFO entry
    // S_START | start bit (low)
    // S_DATA  | 8 data bits, LSB first
    // S_STOP  | stop bit (high)
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_e;

    logic [15:0]   mem_q [RAM_WORDS];
    logic [7:0]    fifo_q [4];
    logic [15:0]   rdata_q, gpio_q, cyc_q;
    logic [1:0]    wptr_q, rptr_q;
    logic [2:0]    count_q, count_d;
    tx_state_e     state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;

    logic          rd_en, wr_en, push, push_ok, pop;
    logic          fifo_full, fifo_empty;
    logic [15:0]   status, rd_mux;

    assign rd_en      = re & ~rst;
    assign wr_en      = we & ~rst;
    assign fifo_full  = (count_q == 3'd4);
    assign fifo_empty = (count_q == 3'd0);
    assign push       = wr_en && (waddr == A_TXDATA);
    // A pop in the same edge frees a slot, so a push into a full FIFO still lands.
    assign push_ok    = push && (!fifo_full || pop);
    assign status     = {11'd0, count_q, fifo_empty && (state_q == S_IDLE), fifo_full};

    assign rdata    = rdata_q;
    assign gpio_out = gpio_q;
    assign uart_tx  = tx_q;

    always_comb begin
        rd_mux = '0;
        if (raddr < RAM_LIMIT) begin
            rd_mux = mem_q[raddr[AW-1:0]];
        end else begin
            unique case (raddr)
                A_GPIO:   rd_mux = gpio_q;
                A_CYCLES: rd_mux = cyc_q;
                A_STATUS: rd_mux = status;
                default:  rd_mux = '0;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_START;
                    timer_d = BIT_LAST;
                    shift_d = fifo_q[rptr_q];
                end
            end
            S_START: begin
                if (timer_q == '0) begin
                    state_d = S_DATA;
                    timer_d = BIT_LAST;
                    bit_d   = 3'd0;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_DATA: begin
                if (timer_q == '0) begin
                    timer_d = BIT_LAST;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_STOP: begin
                if (timer_q == '0) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = S_START;
                        timer_d = BIT_LAST;
                        shift_d = fifo_q[rptr_q];
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        unique case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase

        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
            gpio_q  <= '0;
            cyc_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (rd_en) rdata_q <= rd_mux;
            if (wr_en && (waddr == A_GPIO)) gpio_q <= wdata;
            cyc_q   <= (wr_en && (waddr == A_CYCLES)) ? 16'd0 : cyc_q + 16'd1;
            if (push_ok) wptr_q <= wptr_q + 2'd1;
            if (pop) rptr_q <= rptr_q + 2'd1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && (waddr < RAM_LIMIT)) mem_q[waddr[AW-1:0]] <= wdata;
        if (push_ok) fifo_q[wptr_q] <= wdata[7:0];
    end

endmodule

// File: tb/tb_data_bus.sv
// Directed bench for data_bus: bus decode, read timing, CYCLES, UART framing, FIFO limits, reset.
module tb_data_bus;
    localparam int CPB = 4;

    logic        clk;
    logic        rst;
    logic [15:0] raddr, waddr, wdata;
    logic        re, we;
    logic [15:0] rdata, gpio_out;
    logic        uart_tx;

    int n_tests = 0;
    int n_fail  = 0;

    data_bus #(.RAM_WORDS(1024), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst),
        .raddr(raddr), .re(re), .rdata(rdata),
        .waddr(waddr), .wdata(wdata), .we(we),
        .gpio_out(gpio_out), .uart_tx(uart_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        we = 1'b1; waddr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a);
        re = 1'b1; raddr = a;
        tick();
        re = 1'b0;
    endtask

    // Line level for bit slot i (0 = start, 1..8 = data LSB first, 9 = stop).
    function automatic logic frame_bit(input logic [7:0] b, input int i);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        return f[i];
    endfunction

    logic [7:0] bytes [6];

    initial begin
        rst = 1'b1; re = 1'b0; we = 1'b0;
        raddr = '0; waddr = '0; wdata = '0;
        tick();
        tick();
        chk("rst_tx", {15'd0, uart_tx}, 16'h0001);
        chk("rst_gpio", gpio_out, 16'h0000);
        chk("rst_rdata", rdata, 16'h0000);
        rst = 1'b0;
        rd(16'hFF03);
        chk("rst_status", rdata, 16'h0002);
        rd(16'hFF01);
        chk("rst_cycles", rdata, 16'h0001);

        wr(16'hFF00, 16'hA5C3);
        chk("gpio_out", gpio_out, 16'hA5C3);
        rd(16'hFF00);
        chk("gpio_rd", rdata, 16'hA5C3);

        wr(16'h0010, 16'h1234);
        rd(16'h0010);
        chk("ram_rd", rdata, 16'h1234);
        raddr = 16'hFF00;
        tick(); tick(); tick();
        chk("ram_hold", rdata, 16'h1234);

        we = 1'b1; waddr = 16'h0010; wdata = 16'hBEEF;
        re = 1'b1; raddr = 16'h0010;
        tick();
        we = 1'b0; re = 1'b0;
        chk("rbw_old", rdata, 16'h1234);
        rd(16'h0010);
        chk("rbw_new", rdata, 16'hBEEF);

        wr(16'h0000, 16'h1111);
        wr(16'h03FF, 16'h2222);
        wr(16'h0400, 16'h7777);
        rd(16'h03FF);
        chk("ram_top", rdata, 16'h2222);
        rd(16'h0000);
        chk("ram_noalias", rdata, 16'h1111);
        rd(16'h0400);
        chk("unmapped_rd", rdata, 16'h0000);

        // Counter is 0 after the write edge, so the 6th edge later samples 5.
        wr(16'hFF01, 16'hFFFF);
        repeat (5) tick();
        rd(16'hFF01);
        chk("cycles_clr", rdata, 16'h0005);
        rd(16'h8000);
        chk("rd_8000", rdata, 16'h0000);
        rd(16'hFF02);
        chk("rd_txdata", rdata, 16'h0000);
        wr(16'hFF03, 16'hFFFF);
        rd(16'hFF03);
        chk("status_ro", rdata, 16'h0002);

        wr(16'hFF02, 16'h00A5);
        chk("a5_pre", {15'd0, uart_tx}, 16'h0001);
        for (int k = 0; k < 40; k++) begin
            if (k == 0) begin
                re = 1'b1; raddr = 16'hFF03;
            end
            tick();
            re = 1'b0;
            chk("a5_bit", {15'd0, uart_tx}, {15'd0, frame_bit(8'hA5, k / CPB)});
        end
        chk("a5_status", rdata, 16'h0004);
        tick();
        chk("a5_idle", {15'd0, uart_tx}, 16'h0001);
        rd(16'hFF03);
        chk("a5_status_end", rdata, 16'h0002);

        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
        bytes[3] = 8'h44; bytes[4] = 8'h55; bytes[5] = 8'h66;
        for (int k = 0; k <= 205; k++) begin
            if (k < 6) begin
                we = 1'b1; waddr = 16'hFF02; wdata = {8'hEE, bytes[k]};
            end
            if (k == 6 || k == 205) begin
                re = 1'b1; raddr = 16'hFF03;
            end
            tick();
            we = 1'b0; re = 1'b0;
            if (k >= 1 && k <= 200)
                chk("b2b_bit", {15'd0, uart_tx},
                    {15'd0, frame_bit(bytes[(k - 1) / 40], ((k - 1) % 40) / CPB)});
            else
                chk("b2b_idle", {15'd0, uart_tx}, 16'h0001);
            if (k == 6) chk("b2b_status_full", rdata, 16'h0011);
        end
        chk("b2b_status_end", rdata, 16'h0002);

        wr(16'hFF02, 16'h003C);
        repeat (6) tick();
        chk("abort_pre", {15'd0, uart_tx}, 16'h0000);
        rst = 1'b1;
        we = 1'b1; waddr = 16'h0010; wdata = 16'h0BAD;
        re = 1'b1; raddr = 16'h0010;
        tick();
        rst = 1'b0; we = 1'b0; re = 1'b0;
        chk("abort_tx", {15'd0, uart_tx}, 16'h0001);
        chk("abort_gpio", gpio_out, 16'h0000);
        chk("abort_rdata", rdata, 16'h0000);
        rd(16'hFF03);
        chk("abort_status", rdata, 16'h0002);
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("abort_line", {15'd0, uart_tx}, 16'h0001);
        end
        rd(16'h0010);
        chk("abort_ram", rdata, 16'hBEEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
